div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sequencer in front of the shared pipelined 32-bit divider pair (signed and unsigned IP cores behind one 2:1 output mux).
- Accepts one RISC-V M-extension divide/remainder request at a time and drives the divider operands and sign mode.
- Holds operands stable for the fixed pipeline latency, applies the RISC-V divide-by-zero and signed-overflow rules without using the divider, and returns a tagged 32-bit result to the EX/WB stage with a valid/ready handshake.

Parameters:
- DIV_LATENCY, 36: cycles from stable operands to a valid divider output.
- TAG_W, 5: width of the destination-register tag carried with each request.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a  in  32  dividend
- req_b  in  32  divisor
- req_tag  in  TAG_W  destination tag
- div_number1  out  32  dividend to divider
- div_number2  out  32  divisor to divider
- div_sign_mode  out  1  0 = signed, 1 = unsigned
- div_ans  in  32  divider quotient
- div_remind  in  32  divider remainder
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts the result
- resp_data  out  32  quotient or remainder
- resp_tag  out  TAG_W  tag of the returned result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_tag=0, div_number1=0, div_number2=0, div_sign_mode=0, busy=0. State is IDLE.
- Request handshake: a request is accepted when req_valid and req_ready are both high. On accept, register a, b, op, tag and drive div_number1=a, div_number2=b, div_sign_mode=op[0]. These outputs stay frozen until the next accept.
- State IDLE (req_ready=1), on accept:
  - b==0 → DONE. Result is 0xFFFFFFFF for DIV/DIVU; a for REM/REMU.
  - Signed op with a==0x80000000 and b==0xFFFFFFFF → DONE. Result is 0x80000000 for DIV; 0 for REM.
  - Otherwise → WAIT, with cnt loaded to DIV_LATENCY-1.
- State WAIT (req_ready=0):
  - Decrement cnt each cycle.
  - When cnt==0, capture div_ans (op[1]=0) or div_remind (op[1]=1) into resp_data and go to DONE.
  - The divider's tvalid output is not used, because the divider runs continuously with inputs always valid. The counter is the sole timing authority.
- State DONE (resp_valid=1, req_ready=0):
  - resp_data and resp_tag are held stable.
  - When resp_ready is high, go to IDLE. resp_valid falls the next cycle.
- Latency:
  - Normal path: resp_valid asserts DIV_LATENCY+1 cycles after accept.
  - Special cases: resp_valid asserts 1 cycle after accept.
- No new request is accepted in the same cycle as the response handshake; req_ready rises the cycle after.
- Reset asserted mid-operation: any in-flight result is discarded and the block returns to reset values next cycle. The divider pipeline is not flushed; its stale output is never captured because cnt restarts on the next accept.
- DIV_LATENCY < 1 is illegal and is flagged by a simulation-time assertion.

Optional Feature:
- Macro: DIV_CTRL_REUSE_EN.
- When defined:
  - The controller keeps the last normal-path quotient and remainder, plus its a, b and sign mode, in a valid flag and registers.
  - An accepted request with identical a, b and op[0] goes straight to DONE using the stored value (latency 1). This covers the DIV-then-REM pairing.
  - Any special-case request leaves the stored entry untouched. rst clears the valid flag.
- When undefined: every non-special request takes the WAIT path, and no storage registers exist.

Decomposition:
- Shared package div_pkg holds:
  - the op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU)
  - the state enum (IDLE, WAIT, DONE)
  - the constants DIV_BY_ZERO_Q=0xFFFFFFFF, INT_MIN=0x80000000 and NEG_ONE=0xFFFFFFFF
- One sub-module: div_special_detect. It is combinational and takes a, b and op. It outputs is_special and special_result.
- The FSM, counter and reuse storage stay in div_ctrl.

Test Plan:
- DIV a=100, b=7 → resp_data=14 exactly DIV_LATENCY+1 cycles after accept; REM with the same operands → 2.
- DIVU a=0xFFFFFFFF, b=2 → 0x7FFFFFFF; DIV with the same operands → 0 (signed −1/2); REMU → 1.
- DIV and REM with b=0, a=0x12345678 → 0xFFFFFFFF and 0x12345678 respectively, each 1 cycle after accept, and the divider result is not captured.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0; both at 1-cycle latency.
- Hold resp_ready=0 for 10 cycles in DONE → resp_valid, resp_data and resp_tag stay stable and req_ready stays 0. Then raise resp_ready → back to IDLE, with req_ready=1 the next cycle.
- Assert rst 5 cycles into WAIT → all outputs return to reset values. A following DIVU 9/3 returns 3 with full latency. With DIV_CTRL_REUSE_EN, a DIV 100/7 followed by REM 100/7 returns 2 one cycle after accept.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divide sequencer: op encoding, FSM states and
// the RISC-V special-case result constants.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE       = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response handshake plus divider operand/result bus of div_ctrl.
// slave = the controller side, master = requester/consumer/divider side.
interface div_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      div_number1;
    logic [31:0]      div_number2;
    logic             div_sign_mode;
    logic [31:0]      div_ans;
    logic [31:0]      div_remind;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  div_ans, div_remind, resp_ready,
        output req_ready, div_number1, div_number2, div_sign_mode,
        output resp_valid, resp_data, resp_tag
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output div_ans, div_remind, resp_ready,
        input  req_ready, div_number1, div_number2, div_sign_mode,
        input  resp_valid, resp_data, resp_tag
    );

endinterface

// File: rtl/div_special_detect.sv
// Combinational detection of divide-by-zero and signed overflow with the
// RISC-V defined result; no latency, no backpressure.
module div_special_detect
    import div_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic        is_special,
    output logic [31:0] special_result
);

    logic is_rem;
    logic is_unsigned;
    logic div_by_zero;
    logic overflow;

    assign is_rem      = op[1];
    assign is_unsigned = op[0];
    assign div_by_zero = (b == 32'd0);
    assign overflow    = !is_unsigned && (a == INT_MIN) && (b == NEG_ONE);
    assign is_special  = div_by_zero | overflow;

    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = is_rem ? a : DIV_BY_ZERO_Q;
        end else if (overflow) begin
            special_result = is_rem ? 32'd0 : INT_MIN;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the shared pipelined divider: one request at a time, result after
// DIV_LATENCY+1 cycles (1 for special cases); req_ready low until the result is taken.
// DIV_CTRL_REUSE_EN: reuse the last divider result for matching a/b/sign.
module div_ctrl
    import div_pkg::*;
#(
    parameter int DIV_LATENCY = 36,
    parameter int TAG_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_DONE = DONE;
    localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rem_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             sign_q;
    logic [31:0]      data_q;
    logic [TAG_W-1:0] tag_q;

    logic             accept;
    logic             div_capture;
    logic             is_special;
    logic [31:0]      special_result;
    logic             reuse_hit;
    logic [31:0]      reuse_data;

    div_special_detect u_special (
        .a              (bus.req_a),
        .b              (bus.req_b),
        .op             (bus.req_op),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign accept      = bus.req_valid && (state_q == S_IDLE);
    assign div_capture = (state_q == S_WAIT) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q    <= bus.req_a;
                        b_q    <= bus.req_b;
                        sign_q <= bus.req_op[0];
                        rem_q  <= bus.req_op[1];
                        tag_q  <= bus.req_tag;
                        if (is_special) begin
                            data_q  <= special_result;
                            state_q <= S_DONE;
                        end else if (reuse_hit) begin
                            data_q  <= reuse_data;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= CNT_W'(DIV_LATENCY - 1);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // The counter alone decides when the divider output is valid.
                    if (div_capture) begin
                        data_q  <= rem_q ? bus.div_remind : bus.div_ans;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DIV_CTRL_REUSE_EN
    logic        reuse_vld;
    logic [31:0] reuse_a;
    logic [31:0] reuse_b;
    logic        reuse_sign;
    logic [31:0] reuse_q;
    logic [31:0] reuse_r;

    // Only normal-path divider results are stored; special cases never touch this.
    always_ff @(posedge clk) begin
        if (rst) begin
            reuse_vld  <= 1'b0;
            reuse_a    <= '0;
            reuse_b    <= '0;
            reuse_sign <= 1'b0;
            reuse_q    <= '0;
            reuse_r    <= '0;
        end else if (div_capture) begin
            reuse_vld  <= 1'b1;
            reuse_a    <= a_q;
            reuse_b    <= b_q;
            reuse_sign <= sign_q;
            reuse_q    <= bus.div_ans;
            reuse_r    <= bus.div_remind;
        end
    end

    assign reuse_hit  = reuse_vld && (bus.req_a == reuse_a) && (bus.req_b == reuse_b)
                        && (bus.req_op[0] == reuse_sign);
    assign reuse_data = bus.req_op[1] ? reuse_r : reuse_q;
`else
    assign reuse_hit  = 1'b0;
    assign reuse_data = '0;
`endif

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.resp_valid    = (state_q == S_DONE);
    assign bus.resp_data     = data_q;
    assign bus.resp_tag      = tag_q;
    assign bus.div_number1   = a_q;
    assign bus.div_number2   = b_q;
    assign bus.div_sign_mode = sign_q;
    assign busy              = (state_q != S_IDLE);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (DIV_LATENCY >= 1) else $error("div_ctrl: DIV_LATENCY must be at least 1");
    end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: pipelined divider model, scoreboard of expected results
// with expected latency, scenario tasks for special cases, hold and reset.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int L     = 36;
    localparam int TAG_W = 5;
`ifdef DIV_CTRL_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = L + 1;
`endif

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    logic prev_vld = 1'b0;
    logic [TAG_W-1:0] tag_ctr = '0;
    exp_t sb[$];

    logic [31:0] q_pipe [L-1];
    logic [31:0] r_pipe [L-1];

    div_ctrl_if #(.TAG_W(TAG_W)) bus ();

    div_ctrl #(.DIV_LATENCY(L), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Divider model: the operand registers count as the first of L stages.
    function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b, input logic uns);
        if (b == 32'd0) return 32'hDEAD_0000;
        if (uns) return a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
    endfunction

    function automatic logic [31:0] model_r(input logic [31:0] a, input logic [31:0] b, input logic uns);
        if (b == 32'd0) return 32'hDEAD_0001;
        if (uns) return a % b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
    endfunction

    always @(posedge clk) begin
        q_pipe[0] <= model_q(bus.div_number1, bus.div_number2, bus.div_sign_mode);
        r_pipe[0] <= model_r(bus.div_number1, bus.div_number2, bus.div_sign_mode);
        for (int i = 1; i < L - 1; i++) begin
            q_pipe[i] <= q_pipe[i-1];
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign bus.div_ans    = q_pipe[L-2];
    assign bus.div_remind = r_pipe[L-2];

    // Scoreboard monitor: pop on each new response, check data, tag and latency.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
            if (bus.resp_valid && !prev_vld) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp data=%h tag=%0d", bus.resp_data, bus.resp_tag);
                end else begin
                    e = sb.pop_front();
                    if (bus.resp_data !== e.data || bus.resp_tag !== e.tag || (cyc - acc_cyc) !== e.lat) begin
                        failures++;
                        $display("FAIL resp data=%h tag=%0d lat=%0d expected data=%h tag=%0d lat=%0d",
                                 bus.resp_data, bus.resp_tag, cyc - acc_cyc, e.data, e.tag, e.lat);
                    end
                end
            end
            prev_vld = bus.resp_valid;
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input int exp_lat, input bit expect_resp);
        int   guard;
        exp_t e;
        guard = 0;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag_ctr;
        bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout req_ready=%b expected 1", bus.req_ready);
        end else if (expect_resp) begin
            e.data = exp_data;
            e.tag  = tag_ctr;
            e.lat  = exp_lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string where);
        logic [31:0] got [8];
        logic [31:0] want [8];
        got[0] = 32'(bus.req_ready);     want[0] = 32'd1;
        got[1] = 32'(bus.resp_valid);    want[1] = 32'd0;
        got[2] = bus.resp_data;          want[2] = 32'd0;
        got[3] = 32'(bus.resp_tag);      want[3] = 32'd0;
        got[4] = bus.div_number1;        want[4] = 32'd0;
        got[5] = bus.div_number2;        want[5] = 32'd0;
        got[6] = 32'(bus.div_sign_mode); want[6] = 32'd0;
        got[7] = 32'(busy);              want[7] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                failures++;
                $display("FAIL %s_reset_out%0d got=%h expected=%h", where, i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("initial");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        send(OP_DIV, 32'd100, 32'd7, 32'd14, L + 1, 1'b1);
        checks++;
        if (bus.div_number1 !== 32'd100 || bus.div_number2 !== 32'd7 || bus.div_sign_mode !== 1'b0
            || bus.req_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL div_drive n1=%h n2=%h sm=%b rdy=%b busy=%b expected 64/7/0/0/1",
                     bus.div_number1, bus.div_number2, bus.div_sign_mode, bus.req_ready, busy);
        end
        drain();
        send(OP_REM, 32'd100, 32'd7, 32'd2, REUSE_LAT, 1'b1);
        drain();
        send(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, L + 1, 1'b1);
        checks++;
        if (bus.div_sign_mode !== 1'b1) begin
            failures++;
            $display("FAIL divu_sign_mode got=%b expected 1", bus.div_sign_mode);
        end
        drain();
        send(OP_DIV, 32'hFFFF_FFFF, 32'd2, 32'd0, L + 1, 1'b1);
        drain();
        send(OP_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, L + 1, 1'b1);
        drain();
    endtask

    task automatic test_special();
        send(OP_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        drain();
        send(OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1'b1);
        drain();
        send(OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        drain();
        send(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1'b1);
        drain();
        send(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        drain();
        send(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
        drain();
        // Stored entry from the last REMU must survive the special cases.
        send(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, REUSE_LAT, 1'b1);
        drain();
        send(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, L + 1, 1'b1);
        drain();
    endtask

    task automatic test_hold();
        int   guard;
        logic [TAG_W-1:0] t;
        guard = 0;
        t = tag_ctr;
        bus.resp_ready = 1'b0;
        send(OP_DIVU, 32'd1000, 32'd10, 32'd100, L + 1, 1'b1);
        while (bus.resp_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (10) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd100 || bus.resp_tag !== t
                || bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold vld=%b data=%h tag=%0d rdy=%b expected 1/64/%0d/0",
                         bus.resp_valid, bus.resp_data, bus.resp_tag, bus.req_ready, t);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release vld=%b rdy=%b expected 0/1", bus.resp_valid, bus.req_ready);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send(OP_DIVU, 32'd9, 32'd3, 32'd3, L + 1, 1'b1);
        drain();
        send(OP_DIV, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL in_wait busy=%b rdy=%b vld=%b expected 1/0/0", busy, bus.req_ready, bus.resp_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("mid");
        rst = 1'b0;
        @(posedge clk); #1;
        // Reset must also clear any stored result, so this takes the full path.
        send(OP_DIVU, 32'd9, 32'd3, 32'd3, L + 1, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 1000));
            send(OP_DIVU, a, b, a / b, L + 1, 1'b1);
            send(OP_REMU, a, b, a % b, REUSE_LAT, 1'b1);
        end
        drain();
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_normal();
        test_special();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog sim_time=%0t expected completion earlier", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
